// File: rtl/program_sequencer.sv
// Program sequencer: walks a flat program image, resolving halt and jump words
// in FETCH and issuing all other words over a valid/ready handshake.
// Optional feature: define JUMP_LIMIT_EN to bound runs of consecutive jumps.
module program_sequencer #(
   parameter int unsigned NUM_WORDS   = 10,
   parameter logic [3:0]  JUMP_OPCODE = 4'b1111
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [32*NUM_WORDS-1:0] program_addr_array,
   input  logic                    start,
   output logic [31:0]             instr,
   output logic                    instr_valid,
   input  logic                    instr_ready,
   output logic [3:0]              pc,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam logic [4:0] NumWordsW = 5'(NUM_WORDS);
   localparam logic [3:0] LastPc    = 4'(NUM_WORDS - 1);

   typedef enum logic [2:0] {StIdle, StFetch, StIssue, StDone, StErr} state_e;

   state_e      state_q, state_d;
   logic [3:0]  pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] word;
   logic        is_halt, is_jump, target_ok, jump_limit;

   // pc never leaves [0, NUM_WORDS), so the select stays inside the image
   assign word      = program_addr_array[{pc_q, 5'd0} +: 32];
   assign is_halt   = (word == 32'd0);
   assign is_jump   = (word[31:28] == JUMP_OPCODE);
   assign target_ok = ({1'b0, word[3:0]} < NumWordsW);

`ifdef JUMP_LIMIT_EN
   logic [4:0] jump_cnt_q, jump_cnt_d;

   assign jump_limit = (jump_cnt_q == 5'd15);

   always_comb begin
      jump_cnt_d = jump_cnt_q;
      if ((state_q inside {StIdle, StDone, StErr}) && start) begin
         jump_cnt_d = '0;
      end else if (state_q == StIssue && instr_ready) begin
         jump_cnt_d = '0;
      end else if (state_q == StFetch && !is_halt && is_jump && target_ok && !jump_limit) begin
         jump_cnt_d = jump_cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jump_cnt_q <= '0;
      end else begin
         jump_cnt_q <= jump_cnt_d;
      end
   end
`else
   assign jump_limit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               pc_d    = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            instr_d = word;
            if (is_halt) begin
               state_d = StDone;
            end else if (is_jump) begin
               if (!target_ok || jump_limit) begin
                  state_d = StErr;
               end else begin
                  pc_d = word[3:0];
               end
            end else begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (instr_ready) begin
               if (pc_q == LastPc) begin
                  state_d = StDone;
               end else begin
                  pc_d    = pc_q + 4'd1;
                  state_d = StFetch;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign instr       = instr_q;
   assign pc          = pc_q;
   assign instr_valid = (state_q == StIssue);
   assign busy        = (state_q == StFetch) || (state_q == StIssue);
   assign done        = (state_q == StDone);
   assign error       = (state_q == StErr);

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed scenarios plus random programs checked
// against a word-by-word interpretation of the program image.
module tb_program_sequencer;

   localparam int N = 10;

`ifdef JUMP_LIMIT_EN
   localparam bit LimitEn = 1'b1;
`else
   localparam bit LimitEn = 1'b0;
`endif

   logic            clk, rst_n, start, instr_ready;
   logic            instr_valid, busy, done, error;
   logic [31:0]     instr;
   logic [3:0]      pc;
   logic [32*N-1:0] program_addr_array;
   logic [31:0]     img [N];
   logic            scramble;

   int          checks, errors;
   logic [35:0] exp_q[$];
   logic [35:0] got_q[$];
   bit          exp_err, exp_hang;
   logic [3:0]  exp_pc;

   // Inverted image is presented while the DUT must not be sampling it
   for (genvar k = 0; k < N; k++) begin : g_img
      assign program_addr_array[k*32 +: 32] = scramble ? ~img[k] : img[k];
   end

   program_sequencer #(
      .NUM_WORDS   (N),
      .JUMP_OPCODE (4'b1111)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .program_addr_array (program_addr_array),
      .start              (start),
      .instr              (instr),
      .instr_valid        (instr_valid),
      .instr_ready        (instr_ready),
      .pc                 (pc),
      .busy               (busy),
      .done               (done),
      .error              (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Interprets the image: halt, jump, out-of-range jump, ordinary issue
   task automatic model_run();
      int          p     = 0;
      int          jumps = 0;
      bit          fin   = 1'b0;
      logic [31:0] w;
      exp_q.delete();
      exp_err = 1'b0;
      exp_pc  = '0;
      for (int s = 0; s < 256 && !fin; s++) begin
         w = img[p];
         if (w == 32'd0) begin
            fin    = 1'b1;
            exp_pc = 4'(p);
         end else if (w[31:28] == 4'hF) begin
            if (int'(w[3:0]) >= N || (LimitEn && jumps == 15)) begin
               fin     = 1'b1;
               exp_err = 1'b1;
               exp_pc  = 4'(p);
            end else begin
               p = int'(w[3:0]);
               jumps++;
            end
         end else begin
            exp_q.push_back({4'(p), w});
            jumps = 0;
            if (p == N - 1) begin
               fin    = 1'b1;
               exp_pc = 4'(p);
            end else begin
               p++;
            end
         end
      end
      exp_hang = !fin;
   endtask

   task automatic gen_random();
      int r;
      for (int k = 0; k < N; k++) begin
         r = int'($urandom_range(0, 11));
         if (r == 0) begin
            img[k] = 32'd0;
         end else if (r <= 2 && k < N - 1) begin
            img[k] = {4'hF, 24'($urandom), 4'($urandom_range(k + 1, N - 1))};
         end else if (r == 3) begin
            img[k] = {4'hF, 24'($urandom), 4'($urandom_range(N, 15))};
         end else begin
            img[k] = {4'($urandom_range(1, 14)), 28'($urandom)};
         end
      end
   endtask

   task automatic run_program(input string tag, input bit rand_mode);
      bit          finished   = 1'b0;
      bit          prev_stall = 1'b0;
      logic [35:0] prev       = '0;
      bit          r;
      int          n;
      model_run();
      got_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 400 && !finished; c++) begin
         if (done || error) begin
            finished = 1'b1;
            start    = 1'b0;
         end else begin
            if (prev_stall) begin
               check({tag, "_hold_valid"}, 36'(instr_valid), 36'd1);
               check({tag, "_hold_word"}, {pc, instr}, prev);
            end
            r           = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            instr_ready = r;
            scramble    = instr_valid;
            start       = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (instr_valid && r) got_q.push_back({pc, instr});
            prev_stall = instr_valid && !r;
            prev       = {pc, instr};
            @(negedge clk);
         end
      end
      instr_ready = 1'b0;
      scramble    = 1'b0;
      start       = 1'b0;
      check({tag, "_finished"}, 36'(finished), 36'd1);
      check({tag, "_count"}, 36'(got_q.size()), 36'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_issue%0d", tag, i), got_q[i], exp_q[i]);
      check({tag, "_error"}, 36'(error), 36'(exp_err));
      check({tag, "_done"}, 36'(done), 36'(!exp_err));
      check({tag, "_pc"}, 36'(pc), 36'(exp_pc));
   endtask

   initial begin
      bit seen;
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      instr_ready = 1'b0;
      scramble    = 1'b0;
      foreach (img[k]) img[k] = '0;
      repeat (2) @(negedge clk);
      check("rst_pc", 36'(pc), 36'd0);
      check("rst_instr", 36'(instr), 36'd0);
      check("rst_valid", 36'(instr_valid), 36'd0);
      check("rst_busy", 36'(busy), 36'd0);
      check("rst_done", 36'(done), 36'd0);
      check("rst_error", 36'(error), 36'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", 36'(busy), 36'd0);
      check("idle_done", 36'(done), 36'd0);

      // Two ordinary words then halt
      img[0] = 32'h1000_0001;
      img[1] = 32'h2000_0002;
      img[2] = 32'h0;
      run_program("basic", 1'b0);
      check("basic_end_pc", 36'(pc), 36'd2);

      // Latency, back-pressure hold, start ignored while busy
      foreach (img[k]) img[k] = '0;
      img[0] = 32'h1234_5678;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("lat1_valid", 36'(instr_valid), 36'd0);
      check("lat1_busy", 36'(busy), 36'd1);
      @(negedge clk);
      check("lat2_valid", 36'(instr_valid), 36'd1);
      check("lat2_instr", 36'(instr), 36'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         @(negedge clk);
         check("stall_valid", 36'(instr_valid), 36'd1);
         check("stall_instr", {pc, instr}, {4'd0, 32'h1234_5678});
      end
      start       = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("hs_valid", 36'(instr_valid), 36'd0);
      check("hs_pc", 36'(pc), 36'd1);
      @(negedge clk);
      check("hs_done", 36'(done), 36'd1);
      check("hs_done_pc", 36'(pc), 36'd1);

      // Forward jump skips words 1-2
      foreach (img[k]) img[k] = '0;
      img[0] = 32'hF000_0003;
      img[1] = 32'hAAAA_0001;
      img[2] = 32'hBBBB_0002;
      img[3] = 32'h5000_0000;
      run_program("jump", 1'b1);
      check("jump_first", (got_q.size() > 0) ? got_q[0] : '1, {4'd3, 32'h5000_0000});

      // Out-of-range jump, sticky error, then recovery
      foreach (img[k]) img[k] = '0;
      img[0] = 32'hF000_000C;
      run_program("badjump", 1'b0);
      repeat (3) @(negedge clk);
      check("err_sticky", 36'(error), 36'd1);
      img[0] = 32'h3000_0003;
      run_program("fixed", 1'b1);

      // Self-jump loop
      foreach (img[k]) img[k] = '0;
      img[0] = 32'hF000_0000;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
`ifdef JUMP_LIMIT_EN
      repeat (15) @(negedge clk);
      check("lim15_error", 36'(error), 36'd0);
      check("lim15_busy", 36'(busy), 36'd1);
      @(negedge clk);
      check("lim16_error", 36'(error), 36'd1);
      check("lim16_pc", 36'(pc), 36'd0);
      check("lim16_valid", 36'(instr_valid), 36'd0);
`else
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("loop_busy", 36'(busy), 36'd1);
         check("loop_valid", 36'(instr_valid), 36'd0);
      end
`endif
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset while an instruction is pending
      foreach (img[k]) img[k] = '0;
      img[0]      = 32'hF000_0005;
      img[5]      = 32'h7777_0000;
      instr_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (instr_valid) seen = 1'b1;
         else @(negedge clk);
      end
      check("mid_seen", 36'(seen), 36'd1);
      check("mid_pc", 36'(pc), 36'd5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 36'(instr_valid), 36'd0);
      check("mid_rst_pc", 36'(pc), 36'd0);
      check("mid_rst_instr", 36'(instr), 36'd0);
      check("mid_rst_busy", 36'(busy), 36'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", 36'(busy), 36'd0);
      check("post_rst_valid", 36'(instr_valid), 36'd0);

      for (int t = 0; t < 25; t++) begin
         gen_random();
         run_program($sformatf("rnd%0d", t), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
